// File: rtl/mul_host_pkg.sv
// mul_host_pkg: shared state encoding and default widths for the multiplier host controller.
package mul_host_pkg;

    localparam int X_WIDTH_DEF = 8;
    localparam int Y_WIDTH_DEF = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [3:0] {
        IDLE, SH_X, WAIT_FX, SH_Y, WAIT_FY, MUL, WAIT_DON, SH_Z, DONE, ERR
    } state_e;

endpackage

// File: rtl/mul_host_if.sv
// mul_host_if: requester handshake plus serial multiplier pins; slave is the controller view.
interface mul_host_if
    import mul_host_pkg::*;
#(
    parameter int X_WIDTH = X_WIDTH_DEF,
    parameter int Y_WIDTH = Y_WIDTH_DEF
);

    logic                       start;
    logic [X_WIDTH-1:0]         x_a;
    logic [Y_WIDTH-1:0]         y_b;
    logic                       busy;
    logic                       res_valid;
    logic [X_WIDTH+Y_WIDTH-1:0] res;
    logic                       err;
    logic                       x_in, sx, y_in, sy, mul, sz;
    logic                       fx, fy, don, fz, z_out;

    modport slave (
        input  start, x_a, y_b, fx, fy, don, fz, z_out,
        output busy, res_valid, res, err, x_in, sx, y_in, sy, mul, sz
    );

    modport master (
        output start, x_a, y_b, fx, fy, don, fz, z_out,
        input  busy, res_valid, res, err, x_in, sx, y_in, sy, mul, sz
    );

endinterface

// File: rtl/mul_host_piso.sv
// mul_host_piso: parallel-load register shifted out MSB first, zero-filling behind.
module mul_host_piso #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] d_i,
    output logic         q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) data_q <= '0;
        else if (load_i) data_q <= d_i;
        else if (shift_i) data_q <= {data_q[W-2:0], 1'b0};
    end

    assign q_o = data_q[W-1];

endmodule

// File: rtl/mul_host_ctrl.sv
// mul_host_ctrl: serialises X/Y into the multiplier, issues Mul and deserialises the product.
// MUL_HOST_TIMEOUT_EN adds a per-wait timeout that aborts to ERR and sets the sticky err flag.
module mul_host_ctrl
    import mul_host_pkg::*;
#(
    parameter int X_WIDTH = X_WIDTH_DEF,
    parameter int Y_WIDTH = Y_WIDTH_DEF
`ifdef MUL_HOST_TIMEOUT_EN
    , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input logic      clk_i,
    input logic      reset_i,
    mul_host_if.slave bus
);

    localparam int Z_WIDTH = X_WIDTH + Y_WIDTH;
    localparam int CW      = $clog2(Z_WIDTH + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, zcnt_q, zcnt_d;
    logic [Z_WIDTH-1:0] z_q, res_q;
    logic               sx_q, sy_q, sz_q, mul_q, cap_q, rv_q, busy_q;
    logic               sx_d, sy_d, sz_d, mul_d, rv_d, busy_d;
    logic               start_ok, cap_last, x_bit, y_bit;

    assign start_ok = state_q == IDLE && bus.start;
    assign cap_last = cap_q && zcnt_q == CW'(Z_WIDTH - 1);

    mul_host_piso #(.W(X_WIDTH)) u_x (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(start_ok),
        .shift_i(state_q == SH_X), .d_i(bus.x_a), .q_o(x_bit)
    );

    mul_host_piso #(.W(Y_WIDTH)) u_y (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(start_ok),
        .shift_i(state_q == SH_Y), .d_i(bus.y_b), .q_o(y_bit)
    );

`ifdef MUL_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wt_q;
    logic          err_q, timeout;
    assign timeout = wt_q == TW'(TIMEOUT - 1);
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wt_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wt_q  <= state_d != state_q ? '0 : wt_q + 1'b1;
            err_q <= state_d == ERR || (err_q && !start_ok);
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            zcnt_q  <= '0;
            z_q     <= '0;
            res_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            sz_q    <= 1'b0;
            mul_q   <= 1'b0;
            cap_q   <= 1'b0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zcnt_q  <= zcnt_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sz_q    <= sz_d;
            mul_q   <= mul_d;
            rv_q    <= rv_d;
            busy_q  <= busy_d;
            // the multiplier presents each Z bit one cycle after the Sz that shifted it
            cap_q   <= sz_q;
            if (start_ok) z_q <= '0;
            else if (cap_q && state_q == SH_Z) z_q <= {z_q[Z_WIDTH-2:0], bus.z_out};
            if (state_q == DONE) res_q <= z_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.start) state_d = SH_X;
            SH_X:     if (cnt_q == CW'(X_WIDTH - 1)) state_d = WAIT_FX;
            WAIT_FX:  if (bus.fx) state_d = SH_Y;
            SH_Y:     if (cnt_q == CW'(Y_WIDTH - 1)) state_d = WAIT_FY;
            WAIT_FY:  if (bus.fy) state_d = MUL;
            MUL:      state_d = WAIT_DON;
            WAIT_DON: if (bus.don) state_d = SH_Z;
            SH_Z:     if (cap_last || bus.fz) state_d = DONE;
            default:  state_d = IDLE;
        endcase
`ifdef MUL_HOST_TIMEOUT_EN
        if (timeout && state_d == state_q && state_q inside {WAIT_FX, WAIT_FY, WAIT_DON, SH_Z})
            state_d = ERR;
`endif
        cnt_d  = state_d != state_q ? '0 : cnt_q == CW'(Z_WIDTH) ? cnt_q : cnt_q + 1'b1;
        zcnt_d = state_q != SH_Z ? '0 : zcnt_q + CW'(cap_q);
    end

    // busy stays up through the res_valid cycle so it falls one cycle after it
    always_comb begin
        sx_d   = state_d == SH_X;
        sy_d   = state_d == SH_Y;
        mul_d  = state_d == MUL;
        sz_d   = state_d == SH_Z && cnt_d < CW'(Z_WIDTH);
        rv_d   = state_q == DONE;
        busy_d = state_d != IDLE || state_q == DONE;
    end

    assign bus.sx        = sx_q;
    assign bus.sy        = sy_q;
    assign bus.sz        = sz_q;
    assign bus.mul       = mul_q;
    assign bus.x_in      = x_bit;
    assign bus.y_in      = y_bit;
    assign bus.res       = res_q;
    assign bus.res_valid = rv_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mul_host_ctrl.sv
// tb_mul_host_ctrl: directed vectors against a behavioural serial multiplier responder.
module tb_mul_host_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [7:0]  xs, ys;
    logic [15:0] prod;
    int          xn, yn, xw, yw, dw, zi;
    bit          mseen, szp;
    int          fx_dly = 0;
    int          don_dly = 0;

    mul_host_if #(.X_WIDTH(8), .Y_WIDTH(8)) bus ();

    mul_host_ctrl dut (.clk_i(clk), .reset_i(rst), .bus(bus));

    always #5 clk = ~clk;

    // responder: sees registered outputs mid-cycle, so Z bits lag Sz by one cycle
    always @(negedge clk) begin
        if (rst || bus.res_valid || bus.err) begin
            xs = '0; ys = '0; prod = '0;
            xn = 0; yn = 0; xw = 0; yw = 0; dw = 0; zi = 15;
            mseen = 1'b0; szp = 1'b0;
            bus.fx = 1'b0; bus.fy = 1'b0; bus.don = 1'b0; bus.fz = 1'b0; bus.z_out = 1'b0;
        end else begin
            if (bus.sx) begin xs = {xs[6:0], bus.x_in}; xn++; xw = 0; end
            else if (xn == 8) xw++;
            if (bus.sy) begin ys = {ys[6:0], bus.y_in}; yn++; yw = 0; end
            else if (yn == 8) yw++;
            if (bus.mul) begin prod = $signed(xs) * $signed(ys); mseen = 1'b1; dw = 0; end
            else if (mseen) dw++;
            if (szp) begin bus.z_out = zi >= 0 ? prod[zi] : 1'b0; zi--; end
            szp = bus.sz;
            bus.fx  = xn == 8 && xw > fx_dly;
            bus.fy  = yn == 8 && yw > 0;
            bus.don = mseen && dw > don_dly;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_res(input bit hold, output int lat, output int sy1, output int muls, output int b1);
        lat = 0; sy1 = 0; muls = 0; b1 = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!hold) bus.start = 1'b0;
            if (lat == 1) b1 = int'(bus.busy);
            if (bus.sy && sy1 == 0) sy1 = lat;
            if (bus.mul) muls++;
        end while (!bus.res_valid && lat < 300);
        if (!bus.res_valid) chk("res_valid_seen", 0, 1);
    endtask

    task automatic run(input string tag, input logic [7:0] x, input logic [7:0] y, input bit hold,
                       input logic [15:0] exp, input int exp_lat, output int sy1);
        int lat, muls, b1;
        bus.x_a = x; bus.y_b = y; bus.start = 1'b1;
        wait_res(hold, lat, sy1, muls, b1);
        chk({tag, "_res"}, bus.res, exp);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_muls"}, muls, 1);
        chk({tag, "_busy1"}, b1, 1);
    endtask

    initial begin
        int sy1, k;
        bus.start = 1'b0; bus.x_a = '0; bus.y_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_rv", bus.res_valid, 0);
        chk("rst_res", bus.res, 0);
        chk("rst_ser", {bus.sx, bus.sy, bus.sz, bus.mul, bus.x_in, bus.y_in}, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;

        run("t5m3", 8'd5, 8'hFD, 1'b0, 16'hFFF1, 39, sy1);
        chk("t5m3_xs", xs, 8'h05);
        chk("t5m3_ys", ys, 8'hFD);
        chk("t5m3_xn", xn, 8);
        chk("t5m3_yn", yn, 8);
        chk("t5m3_sy1", sy1, 10);
        chk("t5m3_busy39", bus.busy, 1);
        @(posedge clk); #1;
        chk("t5m3_busy40", bus.busy, 0);

        run("tneg", 8'h80, 8'h80, 1'b0, 16'h4000, 39, sy1);
        run("tzero", 8'h00, 8'h7F, 1'b0, 16'h0000, 39, sy1);

        fx_dly = 10; don_dly = 20;
        run("tdly", 8'd5, 8'hFD, 1'b0, 16'hFFF1, 69, sy1);
        chk("tdly_sy1", sy1, 20);
        fx_dly = 0; don_dly = 0;

        bus.x_a = 8'd3; bus.y_b = 8'd4; bus.start = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; bus.start = 1'b0; k++; end while (!bus.sz && k < 100);
        chk("rst_shz_reached", bus.sz, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_shz_busy", bus.busy, 0);
        chk("rst_shz_ser", {bus.sx, bus.sy, bus.sz, bus.mul, bus.x_in, bus.y_in, bus.res_valid}, 0);
        chk("rst_shz_res", bus.res, 0);
        run("t7x9", 8'd7, 8'd9, 1'b0, 16'h003F, 39, sy1);

        run("thold1", 8'd2, 8'd3, 1'b1, 16'h0006, 39, sy1);
        run("thold2", 8'hFE, 8'd4, 1'b0, 16'hFFF8, 39, sy1);

`ifdef MUL_HOST_TIMEOUT_EN
        begin
            int rvs;
            don_dly = 100000; rvs = 0; k = 0;
            bus.x_a = 8'd1; bus.y_b = 8'd1; bus.start = 1'b1;
            do begin
                @(posedge clk); #1; bus.start = 1'b0; k++;
                if (bus.res_valid) rvs++;
            end while (!bus.err && k < 300);
            chk("to_err", bus.err, 1);
            chk("to_lat", k, 84);
            chk("to_rv", rvs, 0);
            @(posedge clk); #1;
            don_dly = 0;
            run("to_next", 8'd2, 8'd2, 1'b0, 16'h0004, 39, sy1);
            chk("to_err_clr", bus.err, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
